// File: rtl/instruction_decode_hazard.sv
`default_nettype none
// ============================================================================
//  instruction_decode_hazard
//  MIPS-style ID stage: decode, register file, hazard detection, branch/jump
//  resolution and the ID/EX pipeline register.
//  Revision: 1.0
// ============================================================================
module instruction_decode_hazard #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int BRANCH_FWD = 1,
    parameter int WB_BYPASS  = 1,
    localparam int REG_W     = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             instrValidInput,
    input  logic [31:0]      instructionInput,
    input  logic [XLEN-1:0]  pc4Input,

    input  logic             regWriteInput,
    input  logic [REG_W-1:0] writeRegisterInput,
    input  logic [XLEN-1:0]  writeDataInput,

    input  logic             exMemReadInput,
    input  logic             exRegWriteInput,
    input  logic [REG_W-1:0] exRegisterInput,

    input  logic             memMemReadInput,
    input  logic             memRegWriteInput,
    input  logic [REG_W-1:0] memRegisterInput,
    input  logic [XLEN-1:0]  memDataInput,

    output logic             validOutput,
    output logic             memToRegOutput,
    output logic             regWriteOutput,
    output logic             memWriteOutput,
    output logic             memReadOutput,
    output logic             aluSrcOutput,
    output logic             regDstOutput,
    output logic [3:0]       aluOpOutput,
    output logic [XLEN-1:0]  immediateExtendedOutput,
    output logic [REG_W-1:0] addressRsOutput,
    output logic [REG_W-1:0] addressRtOutput,
    output logic [REG_W-1:0] addressRdOutput,
    output logic [XLEN-1:0]  dataRsOutput,
    output logic [XLEN-1:0]  dataRtOutput,
    output logic [XLEN-1:0]  pc4Output,

    output logic             stallOutput,
    output logic             branchControlOutput,
    output logic [XLEN-1:0]  pcBranchOutput,
    output logic             jumpOutput,
    output logic [XLEN-1:0]  pcJumpOutput,
    output logic             ifFlushOutput,
    output logic             illegalOutput,

    output logic [15:0]      stallCountOutput
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_FUNC = 4'b0010;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]       opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm_ext;

    assign opcode  = instructionInput[31:26];
    assign rs      = instructionInput[21 +: REG_W];
    assign rt      = instructionInput[16 +: REG_W];
    assign rd      = instructionInput[11 +: REG_W];
    assign imm_ext = {{(XLEN-16){instructionInput[15]}}, instructionInput[15:0]};

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       legal;
    logic       uses_rt;
    logic       is_beq;
    logic       is_bne;
    logic       is_jump;
    logic       ctl_mem_to_reg;
    logic       ctl_reg_write;
    logic       ctl_mem_write;
    logic       ctl_mem_read;
    logic       ctl_alu_src;
    logic       ctl_reg_dst;
    logic [3:0] ctl_alu_op;

    always_comb begin
        legal          = 1'b1;
        uses_rt        = 1'b0;
        is_beq         = 1'b0;
        is_bne         = 1'b0;
        is_jump        = 1'b0;
        ctl_mem_to_reg = 1'b0;
        ctl_reg_write  = 1'b0;
        ctl_mem_write  = 1'b0;
        ctl_mem_read   = 1'b0;
        ctl_alu_src    = 1'b0;
        ctl_reg_dst    = 1'b0;
        ctl_alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                uses_rt       = 1'b1;
                ctl_reg_dst   = 1'b1;
                ctl_reg_write = 1'b1;
                ctl_alu_op    = ALU_FUNC;
            end
            OP_LW: begin
                ctl_alu_src    = 1'b1;
                ctl_mem_read   = 1'b1;
                ctl_mem_to_reg = 1'b1;
                ctl_reg_write  = 1'b1;
            end
            OP_SW: begin
                uses_rt       = 1'b1;
                ctl_alu_src   = 1'b1;
                ctl_mem_write = 1'b1;
            end
            OP_ADDI: begin
                ctl_alu_src   = 1'b1;
                ctl_reg_write = 1'b1;
            end
            OP_BEQ: begin
                uses_rt    = 1'b1;
                is_beq     = 1'b1;
                ctl_alu_op = ALU_SUB;
            end
            OP_BNE: begin
                uses_rt    = 1'b1;
                is_bne     = 1'b1;
                ctl_alu_op = ALU_SUB;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file (entry 0 is never written, so it stays zero)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regWriteInput && (writeRegisterInput != '0)) begin
            regs[writeRegisterInput] <= writeDataInput;
        end
    end

    logic            wb_hit_rs;
    logic            wb_hit_rt;
    logic [XLEN-1:0] read_rs;
    logic [XLEN-1:0] read_rt;

    assign wb_hit_rs = (WB_BYPASS != 0) && regWriteInput &&
                       (writeRegisterInput != '0) && (writeRegisterInput == rs);
    assign wb_hit_rt = (WB_BYPASS != 0) && regWriteInput &&
                       (writeRegisterInput != '0) && (writeRegisterInput == rt);

    always_comb begin
        read_rs = regs[rs];
        read_rt = regs[rt];
        if (wb_hit_rs) begin
            read_rs = writeDataInput;
        end
        if (wb_hit_rt) begin
            read_rt = writeDataInput;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;
    logic load_use;
    logic branch_stall;
    logic mem_wait_stall;
    logic stall;
    logic [XLEN-1:0] branch_a;
    logic [XLEN-1:0] branch_b;

    assign ex_hit_rs  = (exRegisterInput  != '0) && (exRegisterInput  == rs);
    assign ex_hit_rt  = (exRegisterInput  != '0) && (exRegisterInput  == rt);
    assign mem_hit_rs = (memRegisterInput != '0) && (memRegisterInput == rs);
    assign mem_hit_rt = (memRegisterInput != '0) && (memRegisterInput == rt);

    assign load_use = legal && exMemReadInput && (ex_hit_rs || (uses_rt && ex_hit_rt));

    // With forwarding, an ALU result in MEM feeds the comparator directly;
    // without it the branch must wait for that result to reach write-back.
    generate
        if (BRANCH_FWD != 0) begin : g_branch_fwd
            assign mem_wait_stall = 1'b0;
            assign branch_a = (memRegWriteInput && mem_hit_rs) ? memDataInput : read_rs;
            assign branch_b = (memRegWriteInput && mem_hit_rt) ? memDataInput : read_rt;
        end else begin : g_branch_stall
            assign mem_wait_stall = memRegWriteInput && (mem_hit_rs || mem_hit_rt);
            assign branch_a = read_rs;
            assign branch_b = read_rt;
        end
    endgenerate

    assign branch_stall = (is_beq || is_bne) &&
                          ((exRegWriteInput && (ex_hit_rs || ex_hit_rt)) ||
                           (memMemReadInput && (mem_hit_rs || mem_hit_rt)) ||
                           mem_wait_stall);

    assign stall = instrValidInput && (load_use || branch_stall);

    // ------------------------------------------------------------------
    // Branch / jump resolution
    // ------------------------------------------------------------------
    logic operands_equal;
    logic go;

    assign operands_equal      = (branch_a == branch_b);
    assign go                  = instrValidInput && !stall;
    assign stallOutput         = stall;
    assign branchControlOutput = go && ((is_beq && operands_equal) || (is_bne && !operands_equal));
    assign pcBranchOutput      = pc4Input + (imm_ext << 2);
    assign jumpOutput          = go && is_jump;
    assign pcJumpOutput        = {pc4Input[XLEN-1:28], instructionInput[25:0], 2'b00};
    assign ifFlushOutput       = branchControlOutput || jumpOutput;
    assign illegalOutput       = instrValidInput && !legal;

    // ------------------------------------------------------------------
    // ID/EX register: a bubble is all zeros
    // ------------------------------------------------------------------
    logic load_idex;

    assign load_idex = go && legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validOutput             <= 1'b0;
            memToRegOutput          <= 1'b0;
            regWriteOutput          <= 1'b0;
            memWriteOutput          <= 1'b0;
            memReadOutput           <= 1'b0;
            aluSrcOutput            <= 1'b0;
            regDstOutput            <= 1'b0;
            aluOpOutput             <= '0;
            immediateExtendedOutput <= '0;
            addressRsOutput         <= '0;
            addressRtOutput         <= '0;
            addressRdOutput         <= '0;
            dataRsOutput            <= '0;
            dataRtOutput            <= '0;
            pc4Output               <= '0;
        end else if (load_idex) begin
            validOutput             <= 1'b1;
            memToRegOutput          <= ctl_mem_to_reg;
            regWriteOutput          <= ctl_reg_write;
            memWriteOutput          <= ctl_mem_write;
            memReadOutput           <= ctl_mem_read;
            aluSrcOutput            <= ctl_alu_src;
            regDstOutput            <= ctl_reg_dst;
            aluOpOutput             <= ctl_alu_op;
            immediateExtendedOutput <= imm_ext;
            addressRsOutput         <= rs;
            addressRtOutput         <= rt;
            addressRdOutput         <= rd;
            dataRsOutput            <= read_rs;
            dataRtOutput            <= read_rt;
            pc4Output               <= pc4Input;
        end else begin
            validOutput             <= 1'b0;
            memToRegOutput          <= 1'b0;
            regWriteOutput          <= 1'b0;
            memWriteOutput          <= 1'b0;
            memReadOutput           <= 1'b0;
            aluSrcOutput            <= 1'b0;
            regDstOutput            <= 1'b0;
            aluOpOutput             <= '0;
            immediateExtendedOutput <= '0;
            addressRsOutput         <= '0;
            addressRtOutput         <= '0;
            addressRdOutput         <= '0;
            dataRsOutput            <= '0;
            dataRtOutput            <= '0;
            pc4Output               <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCountOutput <= '0;
        end else if (stall && (stallCountOutput != 16'hFFFF)) begin
            stallCountOutput <= stallCountOutput + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_hazard.sv
`default_nettype none
// ============================================================================
//  tb_instruction_decode_hazard
//  Directed and randomized checks of the ID stage against a reference model.
//  Revision: 1.0
// ============================================================================
module tb_instruction_decode_hazard;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrValidInput;
    logic [31:0] instructionInput;
    logic [31:0] pc4Input;
    logic        regWriteInput;
    logic [4:0]  writeRegisterInput;
    logic [31:0] writeDataInput;
    logic        exMemReadInput, exRegWriteInput;
    logic [4:0]  exRegisterInput;
    logic        memMemReadInput, memRegWriteInput;
    logic [4:0]  memRegisterInput;
    logic [31:0] memDataInput;

    logic        validOutput, memToRegOutput, regWriteOutput, memWriteOutput;
    logic        memReadOutput, aluSrcOutput, regDstOutput;
    logic [3:0]  aluOpOutput;
    logic [31:0] immediateExtendedOutput, dataRsOutput, dataRtOutput, pc4Output;
    logic [4:0]  addressRsOutput, addressRtOutput, addressRdOutput;
    logic        stallOutput, branchControlOutput, jumpOutput, ifFlushOutput, illegalOutput;
    logic [31:0] pcBranchOutput, pcJumpOutput;
    logic [15:0] stallCountOutput;

    // Second instance built without branch forwarding
    logic        f0_valid, f0_m2r, f0_rw, f0_mw, f0_mr, f0_as, f0_rd;
    logic [3:0]  f0_aluop;
    logic [31:0] f0_imm, f0_drs, f0_drt, f0_pc4;
    logic [4:0]  f0_ars, f0_art, f0_ard;
    logic        f0_stall, f0_branch, f0_jump, f0_flush, f0_illegal;
    logic [31:0] f0_pcb, f0_pcj;
    logic [15:0] f0_count;

    always #5 clk = ~clk;

    instruction_decode_hazard dut (
        .clk(clk), .reset(reset),
        .instrValidInput(instrValidInput), .instructionInput(instructionInput), .pc4Input(pc4Input),
        .regWriteInput(regWriteInput), .writeRegisterInput(writeRegisterInput), .writeDataInput(writeDataInput),
        .exMemReadInput(exMemReadInput), .exRegWriteInput(exRegWriteInput), .exRegisterInput(exRegisterInput),
        .memMemReadInput(memMemReadInput), .memRegWriteInput(memRegWriteInput),
        .memRegisterInput(memRegisterInput), .memDataInput(memDataInput),
        .validOutput(validOutput), .memToRegOutput(memToRegOutput), .regWriteOutput(regWriteOutput),
        .memWriteOutput(memWriteOutput), .memReadOutput(memReadOutput), .aluSrcOutput(aluSrcOutput),
        .regDstOutput(regDstOutput), .aluOpOutput(aluOpOutput),
        .immediateExtendedOutput(immediateExtendedOutput),
        .addressRsOutput(addressRsOutput), .addressRtOutput(addressRtOutput), .addressRdOutput(addressRdOutput),
        .dataRsOutput(dataRsOutput), .dataRtOutput(dataRtOutput), .pc4Output(pc4Output),
        .stallOutput(stallOutput), .branchControlOutput(branchControlOutput), .pcBranchOutput(pcBranchOutput),
        .jumpOutput(jumpOutput), .pcJumpOutput(pcJumpOutput), .ifFlushOutput(ifFlushOutput),
        .illegalOutput(illegalOutput), .stallCountOutput(stallCountOutput)
    );

    instruction_decode_hazard #(.BRANCH_FWD(0)) dut_nofwd (
        .clk(clk), .reset(reset),
        .instrValidInput(instrValidInput), .instructionInput(instructionInput), .pc4Input(pc4Input),
        .regWriteInput(regWriteInput), .writeRegisterInput(writeRegisterInput), .writeDataInput(writeDataInput),
        .exMemReadInput(exMemReadInput), .exRegWriteInput(exRegWriteInput), .exRegisterInput(exRegisterInput),
        .memMemReadInput(memMemReadInput), .memRegWriteInput(memRegWriteInput),
        .memRegisterInput(memRegisterInput), .memDataInput(memDataInput),
        .validOutput(f0_valid), .memToRegOutput(f0_m2r), .regWriteOutput(f0_rw),
        .memWriteOutput(f0_mw), .memReadOutput(f0_mr), .aluSrcOutput(f0_as),
        .regDstOutput(f0_rd), .aluOpOutput(f0_aluop), .immediateExtendedOutput(f0_imm),
        .addressRsOutput(f0_ars), .addressRtOutput(f0_art), .addressRdOutput(f0_ard),
        .dataRsOutput(f0_drs), .dataRtOutput(f0_drt), .pc4Output(f0_pc4),
        .stallOutput(f0_stall), .branchControlOutput(f0_branch), .pcBranchOutput(f0_pcb),
        .jumpOutput(f0_jump), .pcJumpOutput(f0_pcj), .ifFlushOutput(f0_flush),
        .illegalOutput(f0_illegal), .stallCountOutput(f0_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mregs [32];
    logic [15:0] mcnt, mcnt0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (regWriteInput && writeRegisterInput == a) return writeDataInput;
        return mregs[a];
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};
    endfunction

    // Packed as {memToReg, regWrite, memWrite, memRead, aluSrc, regDst, aluOp}
    function automatic logic [9:0] ctl_of(input logic [5:0] op);
        case (op)
            6'h00:        return 10'b0100010010;
            6'h23:        return 10'b1101100000;
            6'h2B:        return 10'b0010100000;
            6'h08:        return 10'b0100100000;
            6'h04, 6'h05: return 10'b0000000001;
            default:      return 10'b0000000000;
        endcase
    endfunction

    // Stall / branch / jump outcome for a given forwarding option
    task automatic model_resolve(input bit bf, output bit st, output bit tk, output bit jp);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] a, b;
        bit          isbr, usert, lu, bs;
        op    = instructionInput[31:26];
        rs    = instructionInput[25:21];
        rt    = instructionInput[20:16];
        isbr  = (op == 6'h04) || (op == 6'h05);
        usert = (op == 6'h00) || (op == 6'h2B) || isbr;
        lu    = is_legal(op) && exMemReadInput && exRegisterInput != 0 &&
                (exRegisterInput == rs || (usert && exRegisterInput == rt));
        bs    = isbr && (
                  (exRegWriteInput && exRegisterInput != 0 && (exRegisterInput == rs || exRegisterInput == rt)) ||
                  (memMemReadInput && memRegisterInput != 0 && (memRegisterInput == rs || memRegisterInput == rt)) ||
                  (!bf && memRegWriteInput && memRegisterInput != 0 && (memRegisterInput == rs || memRegisterInput == rt)));
        st    = instrValidInput && (lu || bs);
        a     = rd_val(rs);
        b     = rd_val(rt);
        if (bf && memRegWriteInput && memRegisterInput != 0 && memRegisterInput == rs) a = memDataInput;
        if (bf && memRegWriteInput && memRegisterInput != 0 && memRegisterInput == rt) b = memDataInput;
        tk = instrValidInput && !st && ((op == 6'h04 && a == b) || (op == 6'h05 && a != b));
        jp = instrValidInput && !st && (op == 6'h02);
    endtask

    task automatic check_reset_state();
        check_value("rst_valid", {31'd0, validOutput}, 0);
        check_value("rst_ctl", {memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput,
                                aluSrcOutput, regDstOutput, aluOpOutput}, 0);
        check_value("rst_imm", immediateExtendedOutput, 0);
        check_value("rst_addr", {addressRsOutput, addressRtOutput, addressRdOutput}, 0);
        check_value("rst_drs", dataRsOutput, 0);
        check_value("rst_drt", dataRtOutput, 0);
        check_value("rst_pc4", pc4Output, 0);
        check_value("rst_cnt", stallCountOutput, 0);
        check_value("rst_f0", {f0_valid, f0_drs[0], f0_count}, 0);
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcnt  = '0;
        mcnt0 = '0;
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1 check_reset_state();
        #1 reset = 1'b0;
    endtask

    // One clock: combinational checks mid-cycle, registered checks after the edge
    task automatic step();
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, drs, drt;
        logic [9:0]  ctl;
        bit          st1, tk1, jp1, st0, tk0, jp0, ld;
        @(negedge clk);
        #1;
        op  = instructionInput[31:26];
        rs  = instructionInput[25:21];
        rt  = instructionInput[20:16];
        rd  = instructionInput[15:11];
        imm = {{16{instructionInput[15]}}, instructionInput[15:0]};
        model_resolve(1'b1, st1, tk1, jp1);
        model_resolve(1'b0, st0, tk0, jp0);
        check_value("stall", {31'd0, stallOutput}, {31'd0, st1});
        check_value("branch", {31'd0, branchControlOutput}, {31'd0, tk1});
        check_value("jump", {31'd0, jumpOutput}, {31'd0, jp1});
        check_value("flush", {31'd0, ifFlushOutput}, {31'd0, tk1 | jp1});
        check_value("illegal", {31'd0, illegalOutput}, {31'd0, instrValidInput & !is_legal(op)});
        check_value("pc_branch", pcBranchOutput, pc4Input + imm * 4);
        check_value("pc_jump", pcJumpOutput, {pc4Input[31:28], instructionInput[25:0], 2'b00});
        check_value("nf_stall", {31'd0, f0_stall}, {31'd0, st0});
        check_value("nf_branch", {31'd0, f0_branch}, {31'd0, tk0});
        check_value("nf_flush", {31'd0, f0_flush}, {31'd0, tk0 | jp0});
        ld  = instrValidInput && is_legal(op) && !st1;
        ctl = ld ? ctl_of(op) : 10'd0;
        drs = rd_val(rs);
        drt = rd_val(rt);
        @(posedge clk);
        #1;
        if (regWriteInput && writeRegisterInput != 0) mregs[writeRegisterInput] = writeDataInput;
        if (st1 && mcnt != 16'hFFFF) mcnt++;
        if (st0 && mcnt0 != 16'hFFFF) mcnt0++;
        check_value("valid", {31'd0, validOutput}, {31'd0, ld});
        check_value("ctl", {memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput,
                            aluSrcOutput, regDstOutput, aluOpOutput}, {22'd0, ctl});
        check_value("imm", immediateExtendedOutput, ld ? imm : 0);
        check_value("addr", {addressRsOutput, addressRtOutput, addressRdOutput}, ld ? {rs, rt, rd} : 0);
        check_value("data_rs", dataRsOutput, ld ? drs : 0);
        check_value("data_rt", dataRtOutput, ld ? drt : 0);
        check_value("pc4_out", pc4Output, ld ? pc4Input : 0);
        check_value("stall_cnt", stallCountOutput, mcnt);
        check_value("nf_stall_cnt", f0_count, mcnt0);
        check_value("nf_valid", {31'd0, f0_valid},
                    {31'd0, instrValidInput && is_legal(op) && !st0});
    endtask

    function automatic logic [4:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 5));
    endfunction

    task automatic randomize_inputs();
        logic [5:0] op;
        case ($urandom_range(0, 8))
            0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2B;
            3: op = 6'h08;  4: op = 6'h04;  5: op = 6'h05;
            6: op = 6'h02;  7: op = 6'h3F;
            default: op = 6'($urandom_range(0, 63));
        endcase
        instrValidInput    = ($urandom_range(0, 7) != 0);
        instructionInput   = {op, rand_reg(), rand_reg(), 16'($urandom)};
        pc4Input           = $urandom;
        regWriteInput      = ($urandom_range(0, 1) == 1);
        writeRegisterInput = rand_reg();
        writeDataInput     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
        exMemReadInput     = ($urandom_range(0, 2) == 0);
        exRegWriteInput    = ($urandom_range(0, 2) == 0);
        exRegisterInput    = rand_reg();
        memMemReadInput    = ($urandom_range(0, 3) == 0);
        memRegWriteInput   = ($urandom_range(0, 2) == 0);
        memRegisterInput   = rand_reg();
        memDataInput       = 32'($urandom_range(0, 3));
    endtask

    task automatic clear_inputs();
        instrValidInput = 0; instructionInput = 0; pc4Input = 0;
        regWriteInput = 0; writeRegisterInput = 0; writeDataInput = 0;
        exMemReadInput = 0; exRegWriteInput = 0; exRegisterInput = 0;
        memMemReadInput = 0; memRegWriteInput = 0; memRegisterInput = 0; memDataInput = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #3 check_reset_state();
        @(posedge clk);
        #1 reset = 1'b0;

        // add r3,r5,r0 while r5=0x1234 is being written back
        regWriteInput = 1; writeRegisterInput = 5; writeDataInput = 32'h1234;
        instrValidInput = 1; instructionInput = {6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h20};
        step();
        check_value("d_add_rs", dataRsOutput, 32'h1234);
        check_value("d_add_regdst", {31'd0, regDstOutput}, 1);
        check_value("d_add_aluop", {28'd0, aluOpOutput}, 32'h2);

        // sub r6,r4,r0 behind lw r4
        regWriteInput = 0; exMemReadInput = 1; exRegWriteInput = 1; exRegisterInput = 4;
        instructionInput = {6'h00, 5'd4, 5'd0, 5'd6, 5'd0, 6'h22};
        step();
        check_value("d_lu_stall", {31'd0, stallOutput}, 1);
        check_value("d_lu_valid", {31'd0, validOutput}, 0);
        check_value("d_lu_cnt", stallCountOutput, 1);

        // r1 = r2 = 7, then beq r1,r2,-1 from pc4=0x100
        clear_inputs();
        regWriteInput = 1; writeRegisterInput = 1; writeDataInput = 7;
        step();
        writeRegisterInput = 2;
        step();
        regWriteInput = 0; instrValidInput = 1; pc4Input = 32'h100;
        instructionInput = {6'h04, 5'd1, 5'd2, 16'hFFFF};
        step();
        check_value("d_beq_taken", {31'd0, branchControlOutput}, 1);
        check_value("d_beq_target", pcBranchOutput, 32'hFC);
        check_value("d_beq_flush", {31'd0, ifFlushOutput}, 1);

        // r1=9 in the file, MEM producing r2=9, bne r1,r2
        instrValidInput = 0; regWriteInput = 1; writeRegisterInput = 1; writeDataInput = 9;
        step();
        regWriteInput = 0; instrValidInput = 1;
        memRegWriteInput = 1; memRegisterInput = 2; memDataInput = 9;
        instructionInput = {6'h05, 5'd1, 5'd2, 16'h0004};
        step();
        check_value("d_bne_nostall", {31'd0, stallOutput}, 0);
        check_value("d_bne_taken", {31'd0, branchControlOutput}, 0);
        check_value("d_bne_nf_stall", {31'd0, f0_stall}, 1);

        // Illegal opcode, then reset asserted mid-cycle
        clear_inputs();
        instrValidInput = 1; instructionInput = {6'h3F, 26'h0123456};
        step();
        check_value("d_ill_flag", {31'd0, illegalOutput}, 1);
        check_value("d_ill_valid", {31'd0, validOutput}, 0);
        instructionInput = {6'h08, 5'd1, 5'd2, 16'h0010};
        step();
        check_value("d_addi_valid", {31'd0, validOutput}, 1);
        async_reset_pulse();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
            if (i % 500 == 499) async_reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
